edge_detector_multi: RTL
========================

# edge_detector_multi

Parametrised multi-channel edge detector, successor to the single-channel negative-edge detector. Each of `WIDTH` asynchronous inputs passes through a synchroniser and a debounce filter. Each channel then raises a one-cycle event pulse on rising, falling or both edges, selected per channel at runtime. Sticky event flags with per-channel clear and a global `any` summary let slow control logic poll for events it would otherwise miss.

## Interface
Parameters:
- `WIDTH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `FILTER_LEN`, 4: consecutive cycles a synchronised change must persist before it is accepted (≥1; 1 = no filtering).
- `RESET_LEVEL`, 0: value loaded into the synchroniser and filtered level on reset.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `R` in 1: reset, synchronous, active-low (R=0 resets on the next `clk` edge).
- `A` in WIDTH: raw, asynchronous channel inputs.
- `mode` in 2*WIDTH: per-channel edge select; bits [2i+1:2i] control channel i.
- `clr` in WIDTH: per-channel sticky clear, level-sensitive, sampled each edge.
- `Q` out WIDTH: one-cycle event pulse per channel.
- `level` out WIDTH: filtered, synchronised input level.
- `sticky` out WIDTH: latched event flags.
- `any` out 1: OR of `sticky`.

## Operation
- **Mode encoding:** 00 OFF, 01 RISE, 10 FALL, 11 BOTH. OFF suppresses `Q` and `sticky` set, but `level` keeps tracking the input.
- **Synchroniser:** a shift chain of `SYNC_STAGES` flops. `s` is the last stage.
- **Filter:** each channel has a counter of width $clog2(FILTER_LEN+1). On each edge:
  - if `s` == `level`, the counter resets to 0;
  - else if counter == FILTER_LEN-1, `level` <= `s` and the counter resets to 0 (a **flip**);
  - else the counter increments.
- **Detect:** on a flip, `Q[i]` is high for the following cycle only if `mode[i]` matches the flip direction. The new `level` of 1 is a rise; 0 is a fall. `mode` is sampled on the flip edge.
- **Sticky:**
  - `sticky[i]` sets on the same edge that `Q[i]` goes high.
  - `clr[i]` clears it otherwise.
  - When set and clear occur together, set wins, so no event is lost.
- **any:** combinational OR of the registered `sticky`.
- **Reset values:**
  - sync chain = `level` = {WIDTH{RESET_LEVEL}};
  - counters = 0;
  - `Q` = 0, `sticky` = 0, `any` = 0.
- **After reset release:** if `A` differs from RESET_LEVEL, a normal filtered edge is reported with full latency.

## Timing
- **Latency:** number the edge that first samples a stable new `A` as edge 0. `level` and `Q` update at edge SYNC_STAGES+FILTER_LEN-1. With defaults this is edge 5.
- **Pulse width:** `Q` is exactly 1 cycle. Minimum spacing between flips on one channel is FILTER_LEN cycles.
- **Glitch rejection:** a synchronised change that reverts before FILTER_LEN consecutive cycles produces no flip, no `Q` and no `sticky`.
- **Reset mid-filter:** clears the counter and aborts any pending flip. No `Q` is issued during or on exit from reset, except through the post-release rule in Operation.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels assert their `Q` bits on the same edge.

## Structure
- **Package `edge_pkg`:** holds the mode localparams MODE_OFF/MODE_RISE/MODE_FALL/MODE_BOTH and the 2-bit mode typedef.
- **Sub-module `edge_channel`:** one channel containing the synchroniser, filter counter, level register and pulse generation. Parameters: SYNC_STAGES, FILTER_LEN, RESET_LEVEL.
- **Top:** generates WIDTH `edge_channel` instances, plus the `sticky` registers and the `any` OR.

## Test plan
All scenarios use default parameters.
1. **Reset:** R=0 for 2 edges with A=4'b1111 -> `Q`=0, `sticky`=0, `level`=0000 throughout. Release with A=0000 -> no `Q` for 20 cycles.
2. **FALL mode, ch0 (mode[1:0]=10):**
   - A[0] 0→1 held -> `level[0]`=1 at edge 5, `Q[0]` stays 0.
   - Then A[0] 1→0 -> `Q[0]`=1 for exactly one cycle at edge 5; `sticky[0]`=1, `any`=1.
3. **Glitch, ch1 (RISE mode):** A[1] high for 3 cycles then low -> `level[1]` stays 0, no `Q[1]`. High for 4+ cycles -> `Q[1]` pulse.
4. **BOTH mode, ch2:** square wave with period 20 cycles for 40 cycles -> exactly 4 `Q[2]` pulses, each 1 cycle wide, each 5 cycles after the corresponding A edge.
5. **Clear vs set:**
   - `clr[3]`=1 on the same edge as an event -> `sticky[3]`=1.
   - `clr[3]`=1 alone on the next edge -> `sticky[3]`=0, `any`=0.
6. **Reset mid-filter and OFF mode:**
   - A[2] rises, R=0 at edge 3 -> no `Q[2]`. After release, `Q[2]` at full latency.
   - mode=00 -> `level` tracks the input, `Q` and `sticky` never set.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector.
// Holds the per-channel edge-select encoding used by edge_channel and
// edge_detector_multi.
package edge_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_channel.sv
// One edge-detector channel: synchroniser chain, debounce filter, filtered
// level register and a one-cycle event pulse.
// Ports:
//   clk   - clock, all state on rising edge
//   R     - synchronous active-low reset
//   a     - raw asynchronous input
//   mode  - edge select (OFF/RISE/FALL/BOTH)
//   level - filtered, synchronised level
//   q     - registered one-cycle event pulse
//   hit   - combinational "q will be high after this edge"; lets the parent
//           set its sticky flag on the same edge that q rises
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic  clk,
  input  logic  R,
  input  logic  a,
  input  mode_t mode,
  output logic  level,
  output logic  q,
  output logic  hit
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic                   flip;

  function automatic logic edge_match(input mode_t m, input logic rising);
    logic r;
    r = 1'b0;
    case (m)
      MODE_OFF:  r = 1'b0;
      MODE_RISE: r = rising;
      MODE_FALL: r = !rising;
      MODE_BOTH: r = 1'b1;
    endcase
    return r;
  endfunction

  assign s = sync_p0[SYNC_STAGES-1];

  // A flip happens when s has disagreed with level for FILTER_LEN edges in a
  // row; s itself is the new level, so it also gives the edge direction.
  assign flip = (s != level) && (cnt == CNT_LAST);
  assign hit  = flip && edge_match(mode, s);

  always_ff @(posedge clk) begin
    if (!R) begin
      sync_p0 <= {SYNC_STAGES{RESET_LEVEL}};
      level   <= RESET_LEVEL;
      cnt     <= '0;
      q       <= 1'b0;
    end else begin
      // stage: synchroniser shift
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], a};
      // stage: filter and pulse
      q <= hit;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/edge_detector_multi.sv
// Parametrised multi-channel edge detector with debounce, per-channel edge
// select, sticky event flags and a global summary flag.
// Ports:
//   clk    - clock, all logic on rising edge
//   R      - synchronous active-low reset
//   A      - raw asynchronous inputs, one bit per channel
//   mode   - per-channel edge select, bits [2i+1:2i] for channel i
//   clr    - per-channel sticky clear (level-sensitive)
//   Q      - one-cycle event pulses
//   level  - filtered, synchronised input levels
//   sticky - latched event flags
//   any    - OR of sticky
module edge_detector_multi
  import edge_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               R,
  input  logic [WIDTH-1:0]   A,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  output logic [WIDTH-1:0]   Q,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   sticky,
  output logic               any
);

  logic [WIDTH-1:0] hit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clk   (clk),
      .R     (R),
      .a     (A[i]),
      .mode  (mode[2*i +: 2]),
      .level (level[i]),
      .q     (Q[i]),
      .hit   (hit[i])
    );
  end

  // Set has priority over clear so an event arriving while software is
  // clearing the flag is never lost.
  always_ff @(posedge clk) begin
    if (!R) begin
      sticky <= '0;
    end else begin
      sticky <= hit | (sticky & ~clr);
    end
  end

  assign any = |sticky;

endmodule
